k005297_bus_arbiter: RTL and testbench

- Schedules K005297 bubble-DMA word transfers onto the shared 68000 bus.
- Runs the 68000 bus-request handshake: BR_n, BG_n, BGACK_n.
- Grants the DMA engine one transfer per ROT8 revolution in a fixed slot, bounds each burst length, and enforces a CPU holdoff between bursts.
- Sits between the supervisor's timing outputs (ROT8, SYS_RUN_FLAG) and the page-buffer DMA datapath.

---
 rtl/k005297_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_k005297_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/k005297_bus_arbiter.sv
// k005297_bus_arbiter
// Schedules K005297 bubble-DMA word transfers onto the shared 68000 bus.
// Runs the BR_n / BG_n / BGACK_n handshake, grants one word per ROT8
// revolution in slot TXSLOT, caps each tenure at BURST_LEN words and keeps
// the bus with the CPU for HOLDOFF_REVS revolutions after every release.
// Optional build macro: K005297_ARB_TIMEOUT_EN adds a grant-wait timeout
// (TIMEOUT_TICKS) that abandons the request and raises a sticky o_TIMEOUT.
// Without the macro the request waits forever and o_TIMEOUT is tied low.
module k005297_bus_arbiter #(
    parameter int TXSLOT        = 3,
    parameter int BURST_LEN     = 8,
    parameter int HOLDOFF_REVS  = 1,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic       i_MCLK,
    input  logic       i_MRST_n,
    input  logic       i_CLK4M_PCEN_n,
    input  logic       i_SYS_RUN_FLAG,
    input  logic [7:0] i_ROT8,
    input  logic       i_DMA_RQ,
    input  logic       i_DMA_LAST,
    output logic       o_DMA_ACK,
    output logic       o_BR_n,
    input  logic       i_BG_n,
    input  logic       i_BGACK_n,
    output logic       o_BGACK_n,
    output logic       o_BUS_OWN,
    output logic       o_TIMEOUT
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_TAKE,
        ST_OWN,
        ST_RELEASE,
        ST_HOLDOFF
    } state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(BURST_LEN);
    localparam logic [3:0] HOLD_INIT   = 4'(HOLDOFF_REVS);

    state_t     state;
    logic [7:0] burst_cnt;
    logic [7:0] burst_nxt;
    logic [3:0] hold_cnt;
    logic       tick;
    logic       slot_tick;

    // A slot only counts while the rotator is a clean one-hot; a halted
    // (all-zero) or corrupted supervisor must never produce a transfer.
    assign tick      = ~i_CLK4M_PCEN_n;
    assign slot_tick = i_ROT8[TXSLOT] & $onehot(i_ROT8);
    assign burst_nxt = burst_cnt + 8'd1;

`ifdef K005297_ARB_TIMEOUT_EN
    localparam int           TW      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
    logic [TW-1:0] to_cnt;
`else
    // Tied low: the comparison is constant 0 for any legal TIMEOUT_TICKS.
    assign o_TIMEOUT = (TIMEOUT_TICKS < 0);
`endif

    // Bus-tenure FSM; state, counters and every output advance on 4 MHz ticks
    always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state     <= ST_IDLE;
            o_BR_n    <= 1'b1;
            o_BGACK_n <= 1'b1;
            o_DMA_ACK <= 1'b0;
            o_BUS_OWN <= 1'b0;
            burst_cnt <= 8'd0;
            hold_cnt  <= 4'd0;
`ifdef K005297_ARB_TIMEOUT_EN
            o_TIMEOUT <= 1'b0;
            to_cnt    <= '0;
`endif
        end else if (tick) begin
            // ACK is a single-tick strobe; only an OWN slot tick raises it
            o_DMA_ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_SYS_RUN_FLAG && i_DMA_RQ) begin
                        state  <= ST_REQ;
                        o_BR_n <= 1'b0;
`ifdef K005297_ARB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end

                ST_REQ: begin
                    if (!i_SYS_RUN_FLAG) begin
                        state  <= ST_IDLE;
                        o_BR_n <= 1'b1;
                    end else if (!i_BG_n && i_BGACK_n) begin
                        // Granted and the previous master has let go
                        state <= ST_TAKE;
                    end
`ifdef K005297_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        o_BR_n    <= 1'b1;
                        o_TIMEOUT <= 1'b1;
                        hold_cnt  <= HOLD_INIT;
                        state     <= ST_HOLDOFF;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                ST_TAKE: begin
                    o_BGACK_n <= 1'b0;
                    o_BUS_OWN <= 1'b1;
                    o_BR_n    <= 1'b1;
                    burst_cnt <= 8'd0;
`ifdef K005297_ARB_TIMEOUT_EN
                    o_TIMEOUT <= 1'b0;
`endif
                    state     <= i_SYS_RUN_FLAG ? ST_OWN : ST_RELEASE;
                end

                ST_OWN: begin
                    if (!i_SYS_RUN_FLAG) begin
                        state <= ST_RELEASE;
                    end else if (slot_tick) begin
                        if (i_DMA_RQ) begin
                            o_DMA_ACK <= 1'b1;
                            burst_cnt <= burst_nxt;
                        end
                        // LAST and a full burst on the same slot collapse
                        // into one release
                        if (!i_DMA_RQ || i_DMA_LAST || (burst_nxt == BURST_LIMIT)) begin
                            state <= ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    o_BGACK_n <= 1'b1;
                    o_BUS_OWN <= 1'b0;
                    hold_cnt  <= HOLD_INIT;
                    state     <= (HOLD_INIT == 4'd0) ? ST_IDLE : ST_HOLDOFF;
                end

                ST_HOLDOFF: begin
                    // Revolutions are counted on ROT8[0], independent of RUN
                    if (hold_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else if (i_ROT8[0]) begin
                        hold_cnt <= hold_cnt - 4'd1;
                        if (hold_cnt == 4'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k005297_bus_arbiter.sv
// tb_k005297_bus_arbiter
// Drives k005297_bus_arbiter through directed tenure scenarios followed by
// randomized traffic, comparing every output each clock against a
// tenure-level reference model kept in this file. Honours the optional
// K005297_ARB_TIMEOUT_EN build macro in the same way as the design.
module tb_k005297_bus_arbiter;

    localparam int TXSLOT        = 3;
    localparam int BURST_LEN     = 8;
    localparam int HOLDOFF_REVS  = 1;
    localparam int TIMEOUT_TICKS = 64;

    logic       i_MCLK = 1'b0;
    logic       i_MRST_n = 1'b1;
    logic       pcen_n = 1'b0;
    logic       run = 1'b0;
    logic       rq = 1'b0;
    logic       last = 1'b0;
    logic       bg_n = 1'b1;
    logic       bgack_in_n = 1'b1;
    logic [7:0] rot8 = 8'h01;
    logic       dma_ack, br_n, bgack_n, bus_own, timeout;

    k005297_bus_arbiter #(
        .TXSLOT(TXSLOT), .BURST_LEN(BURST_LEN),
        .HOLDOFF_REVS(HOLDOFF_REVS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .i_MCLK(i_MCLK), .i_MRST_n(i_MRST_n), .i_CLK4M_PCEN_n(pcen_n),
        .i_SYS_RUN_FLAG(run), .i_ROT8(rot8), .i_DMA_RQ(rq), .i_DMA_LAST(last),
        .o_DMA_ACK(dma_ack), .o_BR_n(br_n), .i_BG_n(bg_n), .i_BGACK_n(bgack_in_n),
        .o_BGACK_n(bgack_n), .o_BUS_OWN(bus_own), .o_TIMEOUT(timeout)
    );

    always #5 i_MCLK = ~i_MCLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_ack = 0;

    // reference model: where the tenure is, plus its bookkeeping
    localparam int PH_IDLE = 0, PH_ASK = 1, PH_GRANTED = 2, PH_MASTER = 3, PH_DROP = 4, PH_COOL = 5;
    int   m_phase, m_words, m_cool, m_wait;
    logic e_ack, e_br_n, e_bgack_n, e_own, e_to;

    // simple CPU: grants cpu_delay clocks after seeing BR_n low
    bit cpu_auto = 1'b1;
    int cpu_delay = 3;
    int cpu_cnt = 0;
    bit rot_halt = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_words = 0; m_cool = 0; m_wait = 0;
        e_ack = 0; e_br_n = 1; e_bgack_n = 1; e_own = 0; e_to = 0;
    endtask

    // One 4 MHz tick of the reference behaviour, using the inputs seen at the edge
    task automatic model_tick();
        bit slot;
        slot = (rot8 == (8'h01 << TXSLOT));
        e_ack = 0;
        case (m_phase)
            PH_IDLE: if (run && rq) begin m_phase = PH_ASK; e_br_n = 0; m_wait = 0; end
            PH_ASK: begin
                if (!run) begin m_phase = PH_IDLE; e_br_n = 1; end
                else if (!bg_n && bgack_in_n) m_phase = PH_GRANTED;
                else begin
                    m_wait++;
`ifdef K005297_ARB_TIMEOUT_EN
                    if (m_wait == TIMEOUT_TICKS) begin
                        e_br_n = 1; e_to = 1; m_cool = HOLDOFF_REVS; m_phase = PH_COOL;
                    end
`endif
                end
            end
            PH_GRANTED: begin
                e_bgack_n = 0; e_own = 1; e_br_n = 1; e_to = 0; m_words = 0;
                m_phase = run ? PH_MASTER : PH_DROP;
            end
            PH_MASTER: begin
                if (!run) m_phase = PH_DROP;
                else if (slot) begin
                    if (rq) begin e_ack = 1; m_words++; end
                    if (!rq || last || m_words == BURST_LEN) m_phase = PH_DROP;
                end
            end
            PH_DROP: begin
                e_bgack_n = 1; e_own = 0; m_cool = HOLDOFF_REVS;
                m_phase = (HOLDOFF_REVS == 0) ? PH_IDLE : PH_COOL;
            end
            default: begin
                if (m_cool == 0) m_phase = PH_IDLE;
                else if (rot8[0]) begin
                    m_cool--;
                    if (m_cool == 0) m_phase = PH_IDLE;
                end
            end
        endcase
    endtask

    // One MCLK cycle: edge, model step, compare all outputs, then update the supervisor/CPU
    task automatic tick_cycle();
        bit t;
        t = !pcen_n && i_MRST_n;
        @(posedge i_MCLK);
        #1;
        if (t) begin
            model_tick();
            rot8 = rot_halt ? 8'h00 : ((rot8 == 8'h00) ? 8'h01 : {rot8[6:0], rot8[7]});
            if (dma_ack) n_ack++;
        end
        check_val("ack", dma_ack, e_ack);
        check_val("br_n", br_n, e_br_n);
        check_val("bgack_n", bgack_n, e_bgack_n);
        check_val("bus_own", bus_own, e_own);
        check_val("timeout", timeout, e_to);
        if (cpu_auto) begin
            if (!br_n) begin
                if (cpu_cnt >= cpu_delay) bg_n = 1'b0;
                else cpu_cnt++;
            end else begin
                bg_n = 1'b1;
                cpu_cnt = 0;
            end
        end
    endtask

    // Reset between clock edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        #2 i_MRST_n = 1'b0;
        #1;
        check_val("rst_ack", dma_ack, 0);
        check_val("rst_br_n", br_n, 1);
        check_val("rst_bgack_n", bgack_n, 1);
        check_val("rst_own", bus_own, 0);
        check_val("rst_timeout", timeout, 0);
        model_reset();
        @(negedge i_MCLK);
        i_MRST_n = 1'b1;
    endtask

    task automatic drain();
        rq = 1'b0;
        repeat (40) tick_cycle();
    endtask

    // One full tenure from IDLE; optional LAST on word last_at, RUN drop after drop_at words
    task automatic run_tenure(input int last_at, input int drop_at, output int acks);
        bit owned = 0;
        int k = 0;
        n_ack = 0;
        rq = 1'b1;
        while (k < 600 && !(owned && !bus_own)) begin
            last = (last_at > 0 && n_ack == last_at - 1);
            if (drop_at > 0 && n_ack >= drop_at) run = 1'b0;
            tick_cycle();
            if (bus_own) owned = 1;
            k++;
        end
        check_val("tenure_done", 32'(owned && !bus_own), 1);
        acks = n_ack;
        last = 1'b0;
        run = 1'b1;
    endtask

    initial begin
        int acks, k;
        model_reset();
        #1 i_MRST_n = 1'b0;
        #2;
        check_val("init_br_n", br_n, 1);
        check_val("init_bgack_n", bgack_n, 1);
        check_val("init_ack", dma_ack, 0);
        check_val("init_own", bus_own, 0);
        check_val("init_timeout", timeout, 0);
        @(negedge i_MCLK);
        i_MRST_n = 1'b1;
        run = 1'b1;

        // basic tenure: full burst, then re-request only after the holdoff
        cpu_delay = 3;
        run_tenure(0, 0, acks);
        check_val("basic_acks", acks, BURST_LEN);
        k = 0;
        while (k < 40 && br_n) begin tick_cycle(); k++; end
        check_val("basic_rereq", br_n, 0);
        drain();

        // LAST on the third word
        run_tenure(3, 0, acks);
        check_val("last_acks", acks, 3);
        drain();

        // RUN dropped after two words
        run_tenure(0, 2, acks);
        check_val("drop_acks", acks, 2);
        drain();

        // contention: granted while another master still holds BGACK
        cpu_auto = 1'b0; bg_n = 1'b0; bgack_in_n = 1'b0; rq = 1'b1; n_ack = 0;
        repeat (20) tick_cycle();
        check_val("cont_no_ack", n_ack, 0);
        check_val("cont_bgack_n", bgack_n, 1);
        bgack_in_n = 1'b1;
        k = 0;
        while (k < 10 && bgack_n) begin tick_cycle(); k++; end
        check_val("cont_take_lat", k, 2);
        cpu_auto = 1'b1; cpu_cnt = 0;
        k = 0;
        while (k < 200 && bus_own) begin tick_cycle(); k++; end
        drain();

        // async reset in the middle of a tenure, then a clean restart
        rq = 1'b1; n_ack = 0; k = 0;
        while (k < 200 && n_ack < 3) begin tick_cycle(); k++; end
        check_val("rst_pre_acks", n_ack, 3);
        async_reset();
        drain();
        run_tenure(0, 0, acks);
        check_val("rst_restart_acks", acks, BURST_LEN);
        drain();

        // grant never arrives
        cpu_auto = 1'b0; bg_n = 1'b1; rq = 1'b1;
        repeat (80) tick_cycle();
`ifdef K005297_ARB_TIMEOUT_EN
        check_val("to_flag", timeout, 1);
        cpu_auto = 1'b1; cpu_cnt = 0;
        k = 0;
        while (k < 150 && !bus_own) begin tick_cycle(); k++; end
        check_val("to_cleared", timeout, 0);
`else
        check_val("to_flag", timeout, 0);
        check_val("to_br_held", br_n, 0);
        cpu_auto = 1'b1; cpu_cnt = 0;
`endif
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            pcen_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) run = ~run;
            rq = ($urandom_range(0, 7) != 0);
            last = ($urandom_range(0, 5) == 0);
            bgack_in_n = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 199) == 0) rot_halt = ~rot_halt;
            if (br_n && cpu_cnt == 0)
                cpu_delay = ($urandom_range(0, 15) == 0) ? 90 : $urandom_range(0, 6);
            if ($urandom_range(0, 399) == 0) async_reset();
            tick_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
